// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int BCD_W         = 4;
  localparam int SEC_UNITS_MOD = 10;
  localparam int SEC_TENS_MOD  = 6;
  localparam int MIN_MOD       = 10;

  function automatic logic bcd_digit_ok(input logic [BCD_W-1:0] d, input logic [BCD_W-1:0] max_d);
    return d <= max_d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> MOD-1 and borrows from the next digit up.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             dec_in,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  localparam logic [BCD_W-1:0] TOP = BCD_W'(MOD - 1);

  logic [BCD_W-1:0] digit_d, digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load)        digit_d = load_digit;
    else if (dec_in) digit_d = (digit_q == '0) ? TOP : digit_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit      = digit_q;
  assign borrow_out = dec_in & (digit_q == '0);

endmodule

// File: rtl/countdown_timer_bcd.sv
// BCD MM..M:SS countdown timer with start/pause FSM and load validation.
// Optional TIMER_AUTO_RELOAD_EN: on expiry reload the last valid load and keep running.
module countdown_timer_bcd
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 100000000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load,
  input  logic                              start,
  input  logic                              pause,
  input  logic [BCD_W*(MIN_DIGITS+2)-1:0]   load_val,
  output logic [BCD_W*(MIN_DIGITS+2)-1:0]   digits,
  output logic                              running,
  output logic                              done,
  output logic                              done_pulse,
  output logic                              error
);

  localparam int ND = MIN_DIGITS + 2;
  localparam int W  = BCD_W * ND;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_e        state_d, state_q;
  logic [PW-1:0] presc_d, presc_q;
  logic          done_pulse_d, done_pulse_q;
  logic          load_ok, tick, dec, is_zero, one_sec, reload_hit;
  logic          dig_load;
  logic [W-1:0]  dig_val;
  logic [ND:0]   borrow;

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < ND; i++)
      if (!bcd_digit_ok(load_val[i*BCD_W +: BCD_W],
                        (i == 1) ? BCD_W'(SEC_TENS_MOD - 1) : BCD_W'(MIN_MOD - 1)))
        load_ok = 1'b0;
  end

  assign is_zero = (digits == '0);
  assign one_sec = (digits == W'(1));  // the next decrement lands on zero
  assign tick    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
  assign dec     = tick && !load && !pause;

`ifdef TIMER_AUTO_RELOAD_EN
  logic [W-1:0] reload_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                reload_q <= '0;
    else if (load && load_ok)  reload_q <= load_val;
  end

  assign reload_hit = (reload_q != '0);
  assign dig_load   = (load && load_ok) || (dec && one_sec && reload_hit);
  assign dig_val    = load ? load_val : reload_q;
`else
  assign reload_hit = 1'b0;
  assign dig_load   = load && load_ok;
  assign dig_val    = load_val;
`endif

  assign borrow[0] = dec;

  for (genvar i = 0; i < ND; i++) begin : g_dig
    localparam int MOD = (i == 0) ? SEC_UNITS_MOD : (i == 1) ? SEC_TENS_MOD : MIN_MOD;
    bcd_down_digit #(.MOD(MOD)) u_dig (
      .clk        (clk),
      .reset      (reset),
      .load       (dig_load),
      .load_digit (dig_val[i*BCD_W +: BCD_W]),
      .dec_in     (borrow[i]),
      .digit      (digits[i*BCD_W +: BCD_W]),
      .borrow_out (borrow[i+1])
    );
  end

  // Pause dominates start in every state; a pause on a tick cycle freezes the prescaler.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    done_pulse_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        state_d = ST_IDLE;
        presc_d = '0;
      end else begin
        state_d = ST_ERROR;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: if (!pause && start && !is_zero) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            presc_d = '0;
            if (one_sec) begin
              done_pulse_d = 1'b1;
              if (!reload_hit) state_d = ST_DONE;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ST_PAUSE: if (!pause && start) state_d = ST_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign running    = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd: fixed vectors, corner sequences and random stimulus vs a seconds-based model.
module tb_countdown_timer_bcd;

  localparam int MD = 2;
  localparam int TD = 4;
  localparam int W  = 4 * (MD + 2);
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3, S_ERR = 4;

  logic         clk = 1'b0, reset = 1'b0;
  logic         load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] digits;
  logic         running, done, done_pulse, error;

  int errors = 0, checks = 0;
  int m_st, m_secs, m_presc, m_reload;
  logic m_dp;

  typedef struct {
    logic        l, s, p;
    logic [15:0] lv;
    logic [19:0] exp;
  } vec_t;
  vec_t tbl[$];

  countdown_timer_bcd #(.MIN_DIGITS(MD), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .load(load), .start(start), .pause(pause),
    .load_val(load_val), .digits(digits), .running(running), .done(done),
    .done_pulse(done_pulse), .error(error)
  );

  always #5 clk = ~clk;

  function automatic int bcd2sec(input logic [15:0] v);
    int m, s;
    m = int'(v[15:12]) * 10 + int'(v[11:8]);
    s = int'(v[7:4]) * 10 + int'(v[3:0]);
    return m * 60 + s;
  endfunction

  function automatic logic [15:0] sec2bcd(input int n);
    int m, s;
    m = n / 60;
    s = n % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic bcd_valid(input logic [15:0] v);
    return v[15:12] <= 9 && v[11:8] <= 9 && v[7:4] <= 5 && v[3:0] <= 9;
  endfunction

  function automatic logic [19:0] obs();
    return {digits, running, done, done_pulse, error};
  endfunction

  function automatic logic [19:0] mexp();
    return {sec2bcd(m_secs), m_st == S_RUN, m_st == S_DONE, m_dp, m_st == S_ERR};
  endfunction

  function automatic vec_t mk(input logic l, s, p, input logic [15:0] lv, input logic [19:0] e);
    vec_t v;
    v.l = l; v.s = s; v.p = p; v.lv = lv; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (digits,run/done/pulse/err)", name, act, exp);
    end
  endtask

  task automatic mreset();
    m_st = S_IDLE; m_secs = 0; m_presc = 0; m_reload = 0; m_dp = 1'b0;
  endtask

  // Timer behaviour expressed as remaining seconds and a tick counter.
  task automatic mstep(input logic l, s, p, input logic [15:0] lv);
    m_dp = 1'b0;
    if (l) begin
      if (bcd_valid(lv)) begin
        m_secs = bcd2sec(lv); m_reload = m_secs; m_st = S_IDLE; m_presc = 0;
      end else m_st = S_ERR;
    end else if (m_st == S_IDLE) begin
      if (!p && s && m_secs != 0) begin m_st = S_RUN; m_presc = 0; end
    end else if (m_st == S_PAUSE) begin
      if (!p && s) m_st = S_RUN;
    end else if (m_st == S_RUN) begin
      if (p) m_st = S_PAUSE;
      else if (m_presc == TD - 1) begin
        m_presc = 0;
        m_secs  = m_secs - 1;
        if (m_secs == 0) begin
          m_dp = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
          if (m_reload != 0) m_secs = m_reload;
          else m_st = S_DONE;
`else
          m_st = S_DONE;
`endif
        end
      end else m_presc = m_presc + 1;
    end
  endtask

  task automatic cyc(input string name, input logic l, s, p, input logic [15:0] lv);
    load = l; start = s; pause = p; load_val = lv;
    @(posedge clk);
    mstep(l, s, p, lv);
    #1;
    chk(name, obs(), mexp());
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic idle(input string name, input int n);
    for (int k = 0; k < n; k++) cyc(name, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    mreset();
    #1;
    chk("reset_state", obs(), 20'h0);
    @(negedge clk);
    reset = 1'b1;

    tbl.push_back(mk(1, 0, 0, 16'h1000, {16'h1000, 4'b0000}));
    tbl.push_back(mk(0, 1, 0, 16'h0000, {16'h1000, 4'b1000}));
    tbl.push_back(mk(0, 0, 0, 16'h0000, {16'h1000, 4'b1000}));
    tbl.push_back(mk(0, 0, 0, 16'h0000, {16'h1000, 4'b1000}));
    tbl.push_back(mk(0, 0, 0, 16'h0000, {16'h1000, 4'b1000}));
    tbl.push_back(mk(0, 0, 0, 16'h0000, {16'h0959, 4'b1000}));
    tbl.push_back(mk(1, 0, 0, 16'h0060, {16'h0959, 4'b0001}));
    tbl.push_back(mk(0, 1, 0, 16'h0000, {16'h0959, 4'b0001}));
    tbl.push_back(mk(0, 0, 1, 16'h0000, {16'h0959, 4'b0001}));
    tbl.push_back(mk(1, 0, 0, 16'h0100, {16'h0100, 4'b0000}));
    tbl.push_back(mk(0, 1, 0, 16'h0000, {16'h0100, 4'b1000}));
    tbl.push_back(mk(0, 0, 0, 16'h0000, {16'h0100, 4'b1000}));
    tbl.push_back(mk(0, 0, 0, 16'h0000, {16'h0100, 4'b1000}));
    tbl.push_back(mk(0, 0, 0, 16'h0000, {16'h0100, 4'b1000}));
    tbl.push_back(mk(0, 0, 0, 16'h0000, {16'h0059, 4'b1000}));
    tbl.push_back(mk(1, 0, 0, 16'h0005, {16'h0005, 4'b0000}));
    tbl.push_back(mk(1, 0, 0, 16'h9959, {16'h9959, 4'b0000}));
    tbl.push_back(mk(1, 0, 0, 16'h0A00, {16'h9959, 4'b0001}));
    tbl.push_back(mk(1, 0, 0, 16'h0000, {16'h0000, 4'b0000}));
    tbl.push_back(mk(0, 1, 0, 16'h0000, {16'h0000, 4'b0000}));

    foreach (tbl[i]) begin
      cyc("vec_model", tbl[i].l, tbl[i].s, tbl[i].p, tbl[i].lv);
      chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // Count 00:03 down to expiry.
    cyc("t2_load", 1, 0, 0, 16'h0003);
    cyc("t2_start", 0, 1, 0, 16'h0);
    idle("t2_run", 4);
    chk("t2_sec2", obs(), {16'h0002, 4'b1000});
    idle("t2_run", 4);
    chk("t2_sec1", obs(), {16'h0001, 4'b1000});
    idle("t2_run", 4);
`ifdef TIMER_AUTO_RELOAD_EN
    chk("t2_expire", obs(), {16'h0003, 4'b1010});
    idle("t2_after", 1);
    chk("t2_after", obs(), {16'h0003, 4'b1000});
`else
    chk("t2_expire", obs(), {16'h0000, 4'b0110});
    idle("t2_after", 1);
    chk("t2_after", obs(), {16'h0000, 4'b0100});
    cyc("t2_start_ign", 0, 1, 0, 16'h0);
    chk("t2_start_ign", obs(), {16'h0000, 4'b0100});
    cyc("t2_pause_ign", 0, 0, 1, 16'h0);
    chk("t2_pause_ign", obs(), {16'h0000, 4'b0100});
`endif

    // Pause holds the prescaler; pause on a tick suppresses the decrement.
    cyc("t5_load", 1, 0, 0, 16'h0002);
    cyc("t5_start", 0, 1, 0, 16'h0);
    idle("t5_run", 2);
    cyc("t5_pause", 0, 0, 1, 16'h0);
    chk("t5_paused", obs(), {16'h0002, 4'b0000});
    idle("t5_hold", 10);
    chk("t5_held", obs(), {16'h0002, 4'b0000});
    cyc("t5_resume", 0, 1, 0, 16'h0);
    chk("t5_resume", obs(), {16'h0002, 4'b1000});
    idle("t5_run", 1);
    chk("t5_pre_tick", obs(), {16'h0002, 4'b1000});
    idle("t5_run", 1);
    chk("t5_tick", obs(), {16'h0001, 4'b1000});
    idle("t5_run", 3);
    cyc("t5_pause_tick", 0, 0, 1, 16'h0);
    chk("t5_pause_tick", obs(), {16'h0001, 4'b0000});
    cyc("t5_resume2", 0, 1, 0, 16'h0);
    idle("t5_run", 1);
`ifdef TIMER_AUTO_RELOAD_EN
    chk("t5_expire", obs(), {16'h0002, 4'b1010});
`else
    chk("t5_expire", obs(), {16'h0000, 4'b0110});
`endif

`ifdef TIMER_AUTO_RELOAD_EN
    // Auto reload: pulses 8 cycles apart, never leaves RUN.
    cyc("t6_load", 1, 0, 0, 16'h0002);
    cyc("t6_start", 0, 1, 0, 16'h0);
    idle("t6_run", 4);
    chk("t6_sec1", obs(), {16'h0001, 4'b1000});
    idle("t6_run", 4);
    chk("t6_pulse1", obs(), {16'h0002, 4'b1010});
    idle("t6_run", 8);
    chk("t6_pulse2", obs(), {16'h0002, 4'b1010});
`endif

    // Asynchronous reset in the middle of a count.
    cyc("t1_load", 1, 0, 0, 16'h0105);
    cyc("t1_start", 0, 1, 0, 16'h0);
    idle("t1_run", 3);
    #2;
    reset = 1'b0;
    #1;
    mreset();
    chk("t1_async_reset", obs(), 20'h0);
    @(negedge clk);
    reset = 1'b1;
    idle("t1_post", 1);

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      logic l, s, p;
      logic [15:0] lv;
      l = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 9) == 0);
      lv[3:0]   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      lv[7:4]   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      lv[11:8]  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      lv[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      cyc("rand", l, s, p, lv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Parametrised BCD countdown timer holding MM..M:SS.
- Generalises the fixed 2-minute-digit timer:
  - configurable minute-digit count and tick prescaler;
  - full load of minutes and seconds with validation;
  - start/pause/resume state machine;
  - done pulse and level.
- Feeds the 7-segment display driver; digit outputs are packed BCD, least significant digit first.

Parameters:
- MIN_DIGITS, 2, number of BCD minute digits (1..4); total digits ND = MIN_DIGITS+2.
- TICK_DIV, 100000000, clk cycles per one-second tick (>=2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- load  input  1  load load_val (one-cycle strobe)
- start  input  1  start/resume strobe
- pause  input  1  pause strobe
- load_val  input  4*ND  packed BCD: [3:0] sec units, [7:4] sec tens, then minute digits upward
- digits  output  4*ND  current value, same packing
- running  output  1  high in RUN
- done  output  1  high in DONE
- done_pulse  output  1  one-cycle pulse on expiry
- error  output  1  high in ERROR

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE; digits all 0; prescaler 0; running, done, done_pulse, error all 0.
- States: IDLE, RUN, PAUSE, DONE, ERROR.
- Strobe priority per cycle: load > pause > start > tick.
- Validation of load_val:
  - sec tens <= 5 and every other digit <= 9; otherwise invalid.
- load, in any state:
  - valid: digits <= load_val next edge; state IDLE; prescaler cleared.
  - invalid: digits unchanged; state ERROR.
- IDLE:
  - start with digits != 0: RUN, prescaler cleared.
  - start with digits == 0: ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; tick asserted in the cycle count == TICK_DIV-1, then wraps to 0.
  - On tick, decrement by one second with a borrow chain:
    - sec units wraps 0 -> 9 (mod 10);
    - sec tens wraps 0 -> 5 (mod 6);
    - each minute digit wraps 0 -> 9 (mod 10).
  - Borrow propagates only when the lower digit is 0.
  - Decrement producing all-zero:
    - next state DONE;
    - done_pulse high for exactly the cycle after that edge, i.e. coincident with the first DONE cycle;
    - digits = 0.
  - pause: PAUSE; prescaler held (not cleared); a tick in the same cycle is suppressed.
  - start in RUN: ignored.
- PAUSE:
  - start: RUN, prescaler resumes from held count.
  - pause: ignored.
  - No decrement.
- DONE:
  - Holds digits 0 and done = 1 until load.
  - start and pause are ignored.
- ERROR:
  - error = 1; digits hold the last valid value.
  - Only a valid load (-> IDLE) or reset exits.
- Output decode:
  - running = (state == RUN); done = (state == DONE); error = (state == ERROR).
  - Outputs are registered or decoded from the registered state; no combinational path from inputs to outputs.
- Latency:
  - load/start/pause take effect on the next clk edge.
  - First tick occurs TICK_DIV cycles after entering RUN from IDLE.
- Maximum value: 10^MIN_DIGITS - 1 minutes : 59 s.
- Reset mid-count: immediate return to the reset values.

Optional Feature:
- Macro TIMER_AUTO_RELOAD_EN.
- Defined:
  - The last valid loaded value is stored in a reload register.
  - On expiry, the timer pulses done_pulse, reloads digits from the register and stays in RUN; DONE is never entered.
  - The prescaler continues without clearing, so there is no drift.
  - If the reload value is 0 (loaded zero), behaviour is as without the macro.
- Not defined: no reload register; expiry enters DONE as above.

Decomposition:
- Package timer_pkg:
  - state enum (IDLE, RUN, PAUSE, DONE, ERROR);
  - BCD_W = 4;
  - constants SEC_UNITS_MOD = 10, SEC_TENS_MOD = 6, MIN_MOD = 10.
- Sub-module bcd_down_digit:
  - parameter MOD;
  - ports clk, reset, load, load_digit, dec_in, digit, borrow_out;
  - borrow_out = dec_in & (digit == 0);
  - instantiated ND times by generate.
- The top holds the FSM, prescaler, validation, zero detect and the optional reload register.

Test Plan:
All scenarios use TICK_DIV = 4 and MIN_DIGITS = 2.
1. Reset low mid-RUN -> digits = 0000, running = done = error = 0 immediately, without waiting for a clk edge.
2. load 00:03, start -> decrements every 4 cycles 03, 02, 01, 00; done_pulse one cycle coincident with the first done = 1; running = 0.
3. load 10:00, start, 1 tick -> 09:59; load 01:00 -> ... -> 00:59 (borrow across sec tens and minutes).
4. load sec tens = 6 (00:60) -> error = 1, digits keep previous value; start ignored; load 00:05 -> IDLE, error = 0.
5. RUN at prescaler count 2, pause 10 cycles, start -> next tick exactly 1 cycle after resume; pause coincident with tick -> no decrement.
6. With TIMER_AUTO_RELOAD_EN: load 00:02, start -> sequence 02, 01, then done_pulse and digits = 02, running stays 1; second done_pulse 8 cycles later.
